// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared sizing constants and FSM state type for the dft_top
// stream sequencer and its output framer.
package fft_ctrl_pkg;

    localparam int W            = 32;
    localparam int LANES        = 4;
    localparam int FRAME_BEATS  = 512;
    localparam int MIN_GAP      = 512;
    localparam int MAX_INFLIGHT = 2;
    localparam int WDOG_CYCLES  = 4096;

    localparam int BEAT_CNT_W = $clog2(FRAME_BEATS);
    localparam int GAP_CNT_W  = $clog2(MIN_GAP + 1);
    localparam int INFL_W     = $clog2(MAX_INFLIGHT + 1);
    localparam int WDOG_CNT_W = $clog2(WDOG_CYCLES + 1);

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

endpackage

// File: rtl/fft_out_framer.sv
// fft_out_framer: turns the core's next_out pulse plus the following
// FRAME_BEATS words of Y into a registered valid/sop/eop stream.
module fft_out_framer
    import fft_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 next_out,
    input  logic [W*LANES-1:0]   y,
    input  logic                 ready,
    output logic [W*LANES-1:0]   data,
    output logic                 valid,
    output logic                 sop,
    output logic                 eop,
    output logic                 err_overrun
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(FRAME_BEATS - 1);

    logic                  active;
    logic [BEAT_CNT_W-1:0] beat;

    // A fresh next_out always wins over the running count so a new frame
    // realigns the beat index even mid-run; the core cannot stall, so a beat
    // refused downstream is simply lost and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            active      <= 1'b0;
            beat        <= '0;
            data        <= '0;
            valid       <= 1'b0;
            sop         <= 1'b0;
            eop         <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            valid <= active;
            sop   <= active && (beat == '0);
            eop   <= active && (beat == LAST_BEAT);
            if (active) begin
                data <= y;
            end
            if (next_out) begin
                active <= 1'b1;
                beat   <= '0;
            end else if (active) begin
                beat <= beat + 1'b1;
                if (beat == LAST_BEAT) begin
                    active <= 1'b0;
                end
            end
            if (valid && !ready) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fft_stream_sequencer.sv
// fft_stream_sequencer: feeds whole frames into the streaming dft_top core and
// frames its output. Optional watchdog enabled by defining FFT_WATCHDOG_EN.
module fft_stream_sequencer
    import fft_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 in_frame_rdy,
    input  logic [W*LANES-1:0]   in_data,
    output logic                 in_pop,
    output logic                 core_next,
    output logic [W*LANES-1:0]   core_x,
    input  logic                 core_next_out,
    input  logic [W*LANES-1:0]   core_y,
    output logic [W*LANES-1:0]   out_data,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic                 out_eop,
    input  logic                 out_ready,
    output logic [1:0]           inflight,
    output logic                 err_overrun,
    output logic                 err_spurious,
    output logic                 err_timeout
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(FRAME_BEATS - 1);

    state_t                state;
    state_t                state_nxt;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [BEAT_CNT_W-1:0] beat_nxt;
    logic [GAP_CNT_W-1:0]  gap_cnt;
    logic [INFL_W-1:0]     infl;
    logic                  gap_ok;
    logic                  can_start;
    logic                  dec;
    logic                  spurious;
    logic                  wdog_hit;

    assign gap_ok    = gap_cnt >= GAP_CNT_W'(MIN_GAP);
    assign can_start = !reset && enable && in_frame_rdy && gap_ok
                       && (infl < INFL_W'(MAX_INFLIGHT));
    assign spurious  = core_next_out && (infl == '0);
    assign dec       = core_next_out && (infl != '0);
    assign inflight  = infl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    // The first beat pops in the same cycle the start is decided so that
    // back-to-back frames stream without a bubble.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        in_pop    = 1'b0;
        core_next = 1'b0;
        case (state)
            IDLE: begin
                if (can_start) begin
                    in_pop    = 1'b1;
                    core_next = 1'b1;
                    beat_nxt  = BEAT_CNT_W'(1);
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_pop   = !reset;
                beat_nxt = beat_cnt + 1'b1;
                if (beat_cnt == LAST_BEAT) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_x <= '0;
        end else if (in_pop) begin
            core_x <= in_data;
        end
    end

    // Counts cycles since the last core_next, saturating once the gap is met.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt <= GAP_CNT_W'(MIN_GAP);
        end else if (core_next) begin
            gap_cnt <= GAP_CNT_W'(1);
        end else if (!gap_ok) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            infl         <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (wdog_hit) begin
                infl <= core_next ? INFL_W'(1) : '0;
            end else if (core_next && !dec) begin
                infl <= infl + 1'b1;
            end else if (!core_next && dec) begin
                infl <= infl - 1'b1;
            end
            if (spurious) begin
                err_spurious <= 1'b1;
            end
        end
    end

`ifdef FFT_WATCHDOG_EN
    logic [WDOG_CNT_W-1:0] wdog_cnt;

    assign wdog_hit = (infl != '0) && (wdog_cnt >= WDOG_CNT_W'(WDOG_CYCLES));

    // Restarts on every frame start; a lost next_out eventually frees the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (core_next) begin
                wdog_cnt <= WDOG_CNT_W'(1);
            end else if ((infl == '0) || wdog_hit) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            if (wdog_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign wdog_hit    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    fft_out_framer u_framer (
        .clk         (clk),
        .reset       (reset),
        .next_out    (core_next_out),
        .y           (core_y),
        .ready       (out_ready),
        .data        (out_data),
        .valid       (out_valid),
        .sop         (out_sop),
        .eop         (out_eop),
        .err_overrun (err_overrun)
    );

endmodule
